// File: rtl/rv32b_exec_unit.sv
// Execute-stage unit for the RV32 Zba/Zbb/Zbs subset.
// Most ops retire one cycle after issue; CLZ/CTZ/CPOP scan COUNT_STEP bits per cycle.
package rv32b_pkg;
    typedef enum logic [4:0] {
        OP_SH1ADD = 5'd0,  OP_SH2ADD = 5'd1,  OP_SH3ADD = 5'd2,  OP_ANDN  = 5'd3,
        OP_ORN    = 5'd4,  OP_XNOR   = 5'd5,  OP_CLZ    = 5'd6,  OP_CTZ   = 5'd7,
        OP_CPOP   = 5'd8,  OP_MAX    = 5'd9,  OP_MAXU   = 5'd10, OP_MIN   = 5'd11,
        OP_MINU   = 5'd12, OP_SEXTB  = 5'd13, OP_SEXTH  = 5'd14, OP_ZEXTH = 5'd15,
        OP_ROL    = 5'd16, OP_ROR    = 5'd17, OP_ORCB   = 5'd18, OP_REV8  = 5'd19,
        OP_BCLR   = 5'd20, OP_BEXT   = 5'd21, OP_BINV   = 5'd22, OP_BSET  = 5'd23
    } rv32b_op_t;

    typedef struct packed {
        logic      claim;
        rv32b_op_t op;
    } rv32b_decode_t;
endpackage

// state  | meaning
// IDLE   | ready to accept; simple ops and single-step counts retire from here
// COUNT  | multi-cycle bit scan in progress, busy asserted
module rv32b_exec_unit #(
    parameter int COUNT_STEP = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     start,
    input  rv32b_pkg::rv32b_decode_t rv32b_control,
    input  logic [31:0]              rs1_data,
    input  logic [31:0]              rs2_data,
    input  logic                     flush,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              result
);
    import rv32b_pkg::*;

    localparam int STEPS = 32 / COUNT_STEP;
    localparam logic [4:0] CNT_LOAD = (STEPS > 1) ? 5'(STEPS - 2) : 5'd0;

    typedef enum logic {ST_IDLE, ST_COUNT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic [5:0]  acc_q, acc_d;
    logic        found_q, found_d;
    logic        cpop_q, cpop_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic [4:0]  sh;
    logic [63:0] rol64, ror64;
    logic [31:0] a_rev, orc, simple_res;
    logic [31:0] src, step_data;
    logic [5:0]  acc_in, step_acc;
    logic        found_in, cpop_in, step_found;
    logic        accept, is_count;

    always_comb begin
        sh    = rs2_data[4:0];
        rol64 = {rs1_data, rs1_data} << sh;
        ror64 = {rs1_data, rs1_data} >> sh;
        a_rev = '0;
        orc   = '0;
        for (int i = 0; i < 32; i++) a_rev[i] = rs1_data[31-i];
        for (int j = 0; j < 4; j++) orc[8*j +: 8] = (rs1_data[8*j +: 8] != 8'h00) ? 8'hFF : 8'h00;

        simple_res = '0;
        case (rv32b_control.op)
            OP_SH1ADD: simple_res = (rs1_data << 1) + rs2_data;
            OP_SH2ADD: simple_res = (rs1_data << 2) + rs2_data;
            OP_SH3ADD: simple_res = (rs1_data << 3) + rs2_data;
            OP_ANDN:   simple_res = rs1_data & ~rs2_data;
            OP_ORN:    simple_res = rs1_data | ~rs2_data;
            OP_XNOR:   simple_res = ~(rs1_data ^ rs2_data);
            OP_MAX:    simple_res = ($signed(rs1_data) > $signed(rs2_data)) ? rs1_data : rs2_data;
            OP_MAXU:   simple_res = (rs1_data > rs2_data) ? rs1_data : rs2_data;
            OP_MIN:    simple_res = ($signed(rs1_data) < $signed(rs2_data)) ? rs1_data : rs2_data;
            OP_MINU:   simple_res = (rs1_data < rs2_data) ? rs1_data : rs2_data;
            OP_SEXTB:  simple_res = {{24{rs1_data[7]}}, rs1_data[7:0]};
            OP_SEXTH:  simple_res = {{16{rs1_data[15]}}, rs1_data[15:0]};
            OP_ZEXTH:  simple_res = {16'h0000, rs1_data[15:0]};
            OP_ROL:    simple_res = rol64[63:32];
            OP_ROR:    simple_res = ror64[31:0];
            OP_ORCB:   simple_res = orc;
            OP_REV8:   simple_res = {rs1_data[7:0], rs1_data[15:8], rs1_data[23:16], rs1_data[31:24]};
            OP_BCLR:   simple_res = rs1_data & ~(32'h1 << sh);
            OP_BSET:   simple_res = rs1_data | (32'h1 << sh);
            OP_BINV:   simple_res = rs1_data ^ (32'h1 << sh);
            OP_BEXT:   simple_res = {31'h0, rs1_data[sh]};
            default:   simple_res = '0;
        endcase
    end

    // CTZ is scanned as CLZ of the bit-reversed operand, so one MSB-first walker serves all three.
    always_comb begin
        if (state_q == ST_COUNT) begin
            src      = data_q;
            acc_in   = acc_q;
            found_in = found_q;
            cpop_in  = cpop_q;
        end else begin
            src      = (rv32b_control.op == OP_CTZ) ? a_rev : rs1_data;
            acc_in   = '0;
            found_in = 1'b0;
            cpop_in  = (rv32b_control.op == OP_CPOP);
        end
        step_acc   = acc_in;
        step_found = found_in;
        for (int i = 0; i < COUNT_STEP; i++) begin
            if (cpop_in) begin
                step_acc = step_acc + {5'd0, src[31-i]};
            end else if (!step_found) begin
                if (src[31-i]) step_found = 1'b1;
                else           step_acc   = step_acc + 6'd1;
            end
        end
        step_data = src << COUNT_STEP;
    end

    assign is_count = (rv32b_control.op == OP_CLZ) || (rv32b_control.op == OP_CTZ) ||
                      (rv32b_control.op == OP_CPOP);
    assign accept   = start && rv32b_control.claim && (state_q == ST_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        acc_d    = acc_q;
        found_d  = found_q;
        cpop_d   = cpop_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!is_count) begin
                            result_d = simple_res;
                            done_d   = 1'b1;
                        end else if (STEPS > 1) begin
                            state_d = ST_COUNT;
                            cnt_d   = CNT_LOAD;
                            data_d  = step_data;
                            acc_d   = step_acc;
                            found_d = step_found;
                            cpop_d  = cpop_in;
                        end else begin
                            result_d = {26'd0, step_acc};
                            done_d   = 1'b1;
                        end
                    end
                end
                ST_COUNT: begin
                    if (cnt_q == 5'd0) begin
                        result_d = {26'd0, step_acc};
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q - 5'd1;
                        data_d  = step_data;
                        acc_d   = step_acc;
                        found_d = step_found;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            acc_q    <= '0;
            found_q  <= 1'b0;
            cpop_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            acc_q    <= acc_d;
            found_q  <= found_d;
            cpop_q   <= cpop_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == ST_COUNT);
    assign done   = done_q;
    assign result = result_q;
endmodule

// File: tb/tb_rv32b_exec_unit.sv
// Bench for rv32b_exec_unit: vector table across three COUNT_STEP builds plus handshake,
// flush and reset sequences on the default build; expected results ride a due-cycle queue.
module tb_rv32b_exec_unit;
    import rv32b_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          nRST, start, flush, multi_en, start_m;
    rv32b_decode_t ctrl;
    logic [31:0]   rs1, rs2;
    logic          busy8, done8, busy1, done1, busy32, done32;
    logic [31:0]   res8, res1, res32;

    assign start_m = start & multi_en;

    rv32b_exec_unit #(.COUNT_STEP(8)) u8 (
        .CLK(CLK), .nRST(nRST), .start(start), .rv32b_control(ctrl), .rs1_data(rs1),
        .rs2_data(rs2), .flush(flush), .busy(busy8), .done(done8), .result(res8));
    rv32b_exec_unit #(.COUNT_STEP(1)) u1 (
        .CLK(CLK), .nRST(nRST), .start(start_m), .rv32b_control(ctrl), .rs1_data(rs1),
        .rs2_data(rs2), .flush(flush), .busy(busy1), .done(done1), .result(res1));
    rv32b_exec_unit #(.COUNT_STEP(32)) u32 (
        .CLK(CLK), .nRST(nRST), .start(start_m), .rv32b_control(ctrl), .rs1_data(rs1),
        .rs2_data(rs2), .flush(flush), .busy(busy32), .done(done32), .result(res32));

    typedef struct {
        string       name;
        rv32b_op_t   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] val;
        int          due;
    } exp_t;

    vec_t vecs[$];
    exp_t q8[$], q1[$], q32[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string dut, input logic [31:0] got);
        checks++;
        failures++;
        $display("FAIL %s unexpected done: got result %h expected no done", dut, got);
    endtask

    task automatic sample();
        exp_t e;
        if (done8 === 1'b1) begin
            if (q8.size() == 0) unexpected("u8", res8);
            else begin
                e = q8.pop_front();
                check({"u8 ", e.name}, res8, e.val);
                check({"u8 ", e.name, " cycle"}, 32'(cyc), 32'(e.due));
            end
        end
        if (done1 === 1'b1) begin
            if (q1.size() == 0) unexpected("u1", res1);
            else begin
                e = q1.pop_front();
                check({"u1 ", e.name}, res1, e.val);
                check({"u1 ", e.name, " cycle"}, 32'(cyc), 32'(e.due));
            end
        end
        if (done32 === 1'b1) begin
            if (q32.size() == 0) unexpected("u32", res32);
            else begin
                e = q32.pop_front();
                check({"u32 ", e.name}, res32, e.val);
                check({"u32 ", e.name, " cycle"}, 32'(cyc), 32'(e.due));
            end
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cyc++;
        sample();
    endtask

    function automatic bit is_cnt(input rv32b_op_t op);
        return (op == OP_CLZ) || (op == OP_CTZ) || (op == OP_CPOP);
    endfunction

    task automatic drive(input rv32b_op_t op, input logic claim, input logic [31:0] a,
                         input logic [31:0] b);
        start      = 1'b1;
        ctrl.claim = claim;
        ctrl.op    = op;
        rs1        = a;
        rs2        = b;
    endtask

    task automatic expect_res(input string name, input rv32b_op_t op, input logic [31:0] val,
                              input bit multi);
        q8.push_back('{name, val, cyc + (is_cnt(op) ? 4 : 1)});
        if (multi) begin
            q1.push_back('{name, val, cyc + (is_cnt(op) ? 32 : 1)});
            q32.push_back('{name, val, cyc + 1});
        end
    endtask

    task automatic add(input string name, input rv32b_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        vecs.push_back('{name, op, a, b, exp});
    endtask

    initial begin
        add("sh2add",   OP_SH2ADD, 32'd3,          32'd5,          32'd17);
        add("sh1add",   OP_SH1ADD, 32'd3,          32'd5,          32'd11);
        add("sh3add",   OP_SH3ADD, 32'd1,          32'd1,          32'd9);
        add("clz 1000", OP_CLZ,    32'h0000_1000,  32'd0,          32'd19);
        add("clz 0",    OP_CLZ,    32'h0000_0000,  32'd0,          32'd32);
        add("clz msb",  OP_CLZ,    32'h8000_0000,  32'd0,          32'd0);
        add("ctz 0",    OP_CTZ,    32'h0000_0000,  32'd0,          32'd32);
        add("ctz 80",   OP_CTZ,    32'h0000_0080,  32'd0,          32'd7);
        add("ctz msb",  OP_CTZ,    32'h8000_0000,  32'd0,          32'd31);
        add("cpop ff",  OP_CPOP,   32'hFFFF_FFFF,  32'd0,          32'd32);
        add("cpop 2",   OP_CPOP,   32'h8000_0001,  32'd0,          32'd2);
        add("min",      OP_MIN,    32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF);
        add("minu",     OP_MINU,   32'hFFFF_FFFF,  32'd1,          32'd1);
        add("max",      OP_MAX,    32'hFFFF_FFFF,  32'd1,          32'd1);
        add("maxu",     OP_MAXU,   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF);
        add("orc",      OP_ORCB,   32'h0010_0200,  32'd0,          32'h00FF_FF00);
        add("rev8",     OP_REV8,   32'h1234_5678,  32'd0,          32'h7856_3412);
        add("ror",      OP_ROR,    32'h0000_0001,  32'd1,          32'h8000_0000);
        add("rol",      OP_ROL,    32'h8000_0001,  32'd1,          32'h0000_0003);
        add("rol 0",    OP_ROL,    32'hDEAD_BEEF,  32'h20,         32'hDEAD_BEEF);
        add("andn",     OP_ANDN,   32'hF0F0_F0F0,  32'hFF00_FF00,  32'h00F0_00F0);
        add("orn",      OP_ORN,    32'h0000_0000,  32'hFFFF_0000,  32'h0000_FFFF);
        add("xnor",     OP_XNOR,   32'h0F0F_0F0F,  32'h00FF_00FF,  32'hF00F_F00F);
        add("sextb",    OP_SEXTB,  32'h0000_0080,  32'd0,          32'hFFFF_FF80);
        add("sexth",    OP_SEXTH,  32'h1234_8000,  32'd0,          32'hFFFF_8000);
        add("zexth",    OP_ZEXTH,  32'hFFFF_1234,  32'd0,          32'h0000_1234);
        add("bclr",     OP_BCLR,   32'hFFFF_FFFF,  32'd3,          32'hFFFF_FFF7);
        add("bset",     OP_BSET,   32'h0000_0000,  32'd31,         32'h8000_0000);
        add("binv",     OP_BINV,   32'h0000_000F,  32'd0,          32'h0000_000E);
        add("bext",     OP_BEXT,   32'h0000_0010,  32'h24,         32'd1);
        add("bad op",   rv32b_op_t'(5'd30), 32'hFFFF_FFFF, 32'd1,  32'd0);

        nRST = 1'b0; start = 1'b0; flush = 1'b0; multi_en = 1'b0;
        ctrl = '0; rs1 = '0; rs2 = '0;
        repeat (3) tick();
        check("reset busy",   {31'd0, busy8}, 32'd0);
        check("reset done",   {31'd0, done8}, 32'd0);
        check("reset result", res8,           32'd0);
        nRST = 1'b1;
        tick();

        multi_en = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].op, 1'b1, vecs[i].a, vecs[i].b);
            expect_res(vecs[i].name, vecs[i].op, vecs[i].exp, 1'b1);
            tick();
            start = 1'b0;
            repeat (33) tick();
        end
        multi_en = 1'b0;

        drive(OP_SH2ADD, 1'b1, 32'd3, 32'd5);
        expect_res("sh2add hs", OP_SH2ADD, 32'd17, 1'b0);
        tick();
        check("sh2add busy", {31'd0, busy8}, 32'd0);
        start = 1'b0;
        tick();

        drive(OP_CLZ, 1'b1, 32'h0000_1000, 32'd0);
        expect_res("clz busy-ignore", OP_CLZ, 32'd19, 1'b0);
        tick();
        check("busy N+1", {31'd0, busy8}, 32'd1);
        drive(OP_SH1ADD, 1'b1, 32'd3, 32'd5);
        tick();
        check("busy N+2", {31'd0, busy8}, 32'd1);
        start = 1'b0;
        tick();
        check("busy N+3", {31'd0, busy8}, 32'd1);
        tick();
        check("busy at done", {31'd0, busy8}, 32'd0);
        repeat (3) tick();

        drive(OP_SH1ADD, 1'b0, 32'd3, 32'd5);
        tick();
        check("claim0 done", {31'd0, done8}, 32'd0);
        start = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 6; i++) begin
            drive(OP_SH1ADD, 1'b1, 32'(i), 32'd10);
            expect_res($sformatf("b2b %0d", i), OP_SH1ADD, 32'(i * 2 + 10), 1'b0);
            tick();
        end
        start = 1'b0;
        repeat (2) tick();

        drive(OP_CLZ, 1'b1, 32'h0000_1000, 32'd0);
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        check("flush busy",   {31'd0, busy8}, 32'd0);
        check("flush done",   {31'd0, done8}, 32'd0);
        check("flush result", res8,           32'd20);
        flush = 1'b0;
        repeat (5) tick();

        drive(OP_SH1ADD, 1'b1, 32'd7, 32'd7);
        flush = 1'b1;
        tick();
        check("flush+start done",   {31'd0, done8}, 32'd0);
        check("flush+start result", res8,           32'd20);
        start = 1'b0;
        flush = 1'b0;
        repeat (2) tick();

        drive(OP_CLZ, 1'b1, 32'h0000_1000, 32'd0);
        tick();
        start = 1'b0;
        tick();
        nRST = 1'b0;
        tick();
        check("midcount rst busy",   {31'd0, busy8}, 32'd0);
        check("midcount rst done",   {31'd0, done8}, 32'd0);
        check("midcount rst result", res8,           32'd0);
        nRST = 1'b1;
        repeat (5) tick();

        drive(OP_SH3ADD, 1'b1, 32'd1, 32'd1);
        expect_res("post-reset sh3add", OP_SH3ADD, 32'd9, 1'b0);
        tick();
        start = 1'b0;
        repeat (2) tick();

        check("u8 pending",  32'(q8.size()),  32'd0);
        check("u1 pending",  32'(q1.size()),  32'd0);
        check("u32 pending", 32'(q32.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
